// File: rtl/alu_hilo_muldiv.sv
// alu_hilo_muldiv: EX-stage ALU with single-cycle combinational ops and a
// multi-cycle multiply/divide unit writing the HI/LO register pair.
// Multiply is shift-add and divide is restoring division, both on operand
// magnitudes with one bit per cycle. A final FIX cycle applies sign
// correction and commits HI/LO.
module alu_hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid_in,
  input  logic [5:0]       Func_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] O_out,
  output logic             Branch_out,
  output logic             Jump_out,
  output logic             Busy_out,
  output logic             Stall_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_FIX
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;     // negate product / quotient in FIX
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;       // divide by zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic is_muldiv, is_mfmt, is_hilo, accept, mt_en;
  logic signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_muldiv = (Func_in[5:2] == 4'b0110);
  assign is_mfmt   = (Func_in[5:2] == 4'b0100);
  assign is_hilo   = is_muldiv | is_mfmt;

  assign Busy_out  = (state_q != ST_IDLE);
  assign Stall_out = Valid_in & is_hilo & Busy_out;
  assign accept    = Valid_in & is_muldiv & ~Busy_out;
  assign mt_en     = Valid_in & is_mfmt & Func_in[0] & ~Busy_out;

  // MULT and DIV (funct bit 0 clear) treat operands as signed.
  assign signed_op = ~Func_in[0];
  assign a_neg     = signed_op & A_in[WIDTH-1];
  assign b_neg     = signed_op & B_in[WIDTH-1];
  assign a_mag     = a_neg ? -A_in : A_in;
  assign b_mag     = b_neg ? -B_in : B_in;

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   div_step;
  logic                 unused_rem_msb;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (rem_shift >= {1'b0, opnd_q});
  assign rem_diff  = rem_shift - {1'b0, opnd_q};
  // A restored remainder is always below the divisor, so it fits in WIDTH bits.
  assign rem_new   = div_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign div_step  = {rem_new, acc_q[WIDTH-2:0], div_ge};
  assign unused_rem_msb = rem_diff[WIDTH];

  // Sign-corrected results presented to HI/LO in the FIX cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // ---------------------------------------------------------------------------
  // Next-state logic for the mul/div FSM and HI/LO writes
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first, so no path through the
  // case/if tree leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_ITER;
          cnt_d     = '0;
          is_div_d  = Func_in[1];
          opnd_d    = Func_in[1] ? b_mag : a_mag;
          acc_d     = {{WIDTH{1'b0}}, (Func_in[1] ? a_mag : b_mag)};
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = (B_in == '0);
        end else if (mt_en) begin
          if (Func_in[1]) lo_d = A_in;
          else            hi_d = A_in;
        end
      end

      ST_ITER: begin
        acc_d = is_div_q ? div_step : mul_step;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (is_div_q) begin
          // With a zero divisor the remainder path already yields |A| and the
          // dividend sign restores A; only the quotient needs forcing.
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any partial result.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational ALU result
  // ---------------------------------------------------------------------------
  logic slt_s, slt_u;
  assign slt_s = ($signed(A_in) < $signed(B_in));
  assign slt_u = (A_in < B_in);

  // Result mux keyed on the funct field.
  always_comb begin
    O_out = B_in;
    if (Func_in[5:2] == 4'b1000) begin
      O_out = Func_in[1] ? (A_in - B_in) : (A_in + B_in);
    end else if (Func_in[5:2] == 4'b1001) begin
      unique case (Func_in[1:0])
        2'b00: O_out = A_in & B_in;
        2'b01: O_out = A_in | B_in;
        2'b10: O_out = A_in ^ B_in;
        default: O_out = ~(A_in | B_in);
      endcase
    end else if (Func_in[5:3] == 3'b101) begin
      O_out = {{(WIDTH-1){1'b0}}, (Func_in[0] ? slt_u : slt_s)};
    end else if (Func_in[5:3] == 3'b111) begin
      O_out = A_in;
    end else if (is_mfmt) begin
      unique case (Func_in[1:0])
        2'b00: O_out = hi_q;
        2'b10: O_out = lo_q;
        default: O_out = B_in;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Branch / jump resolution
  // ---------------------------------------------------------------------------
  logic a_is_neg, a_is_zero;
  assign a_is_neg  = A_in[WIDTH-1];
  assign a_is_zero = (A_in == '0);

  // Conditions evaluated only for the 111xxx group.
  always_comb begin
    Branch_out = 1'b0;
    Jump_out   = 1'b0;
    if (Func_in[5:3] == 3'b111) begin
      unique case (Func_in[2:0])
        3'b000: Branch_out = a_is_neg;
        3'b001: Branch_out = ~a_is_neg;
        3'b010,
        3'b011: Jump_out   = 1'b1;
        3'b100: Branch_out = (A_in == B_in);
        3'b101: Branch_out = (A_in != B_in);
        3'b110: Branch_out = a_is_neg | a_is_zero;
        default: Branch_out = ~a_is_neg & ~a_is_zero;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_hilo_muldiv.sv
// tb_alu_hilo_muldiv: directed bench for alu_hilo_muldiv at WIDTH=32 with
// hand-computed expected values.
module tb_alu_hilo_muldiv;

  localparam int W = 32;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101000;
  localparam logic [5:0] F_SLTU  = 6'b101001;
  localparam logic [5:0] F_BLTZ  = 6'b111000;
  localparam logic [5:0] F_J     = 6'b111010;
  localparam logic [5:0] F_BEQ   = 6'b111100;
  localparam logic [5:0] F_BNE   = 6'b111101;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk;
  logic         reset;
  logic         Valid_in;
  logic [5:0]   Func_in;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic [W-1:0] O_out;
  logic         Branch_out;
  logic         Jump_out;
  logic         Busy_out;
  logic         Stall_out;

  int checks = 0;
  int errors = 0;
  int cycles;

  alu_hilo_muldiv #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Valid_in   (Valid_in),
    .Func_in    (Func_in),
    .A_in       (A_in),
    .B_in       (B_in),
    .O_out      (O_out),
    .Branch_out (Branch_out),
    .Jump_out   (Jump_out),
    .Busy_out   (Busy_out),
    .Stall_out  (Stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    Valid_in = v;
    Func_in  = f;
    A_in     = a;
    B_in     = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count negedges with Busy_out high until it drops (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Busy_out) n++;
      else break;
    end
  endtask

  // Issue one mul/div op, wait for completion, then read HI and LO.
  task automatic run_hilo(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
    int n;
    drive(1'b1, f, a, b);
    tick();
    drive(1'b0, F_ADD, '0, '0);
    wait_idle(n);
    check({tag, "_done"}, {31'd0, Busy_out}, 32'd0);
    drive(1'b1, F_MFHI, '0, '0);
    check({tag, "_hi"}, O_out, exp_hi);
    drive(1'b1, F_MFLO, '0, '0);
    check({tag, "_lo"}, O_out, exp_lo);
    drive(1'b0, F_ADD, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, F_MFHI, '0, '0);
    #2;
    check("rst_busy", {31'd0, Busy_out}, 32'd0);
    check("rst_mfhi", O_out, 32'd0);
    drive(1'b1, F_MFLO, '0, '0);
    check("rst_mflo", O_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, F_ADD, '0, '0);

    // MULT with latency measurement
    drive(1'b1, F_MULT, 32'hFFFFFFFD, 32'd5);
    tick();
    drive(1'b0, F_ADD, '0, '0);
    wait_idle(cycles);
    check("mult_busy_cycles", cycles, 32'd33);
    drive(1'b1, F_MFHI, '0, '0);
    check("mult_stall_idle", {31'd0, Stall_out}, 32'd0);
    check("mult_hi", O_out, 32'hFFFFFFFF);
    drive(1'b1, F_MFLO, '0, '0);
    check("mult_lo", O_out, 32'hFFFFFFF1);

    run_hilo("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_hilo("divu",  F_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);
    run_hilo("div",   F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_hilo("divu0", F_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF);
    run_hilo("div0n", F_DIV,   32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 32'hFFFFFFFF);
    run_hilo("divmin", F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MFLO right after MULT stalls; ADD meanwhile proceeds
    drive(1'b1, F_MULT, 32'd7, 32'd6);
    tick();
    drive(1'b1, F_ADD, 32'd2, 32'd3);
    check("busy_add_o", O_out, 32'd5);
    check("busy_add_stall", {31'd0, Stall_out}, 32'd0);
    check("busy_add_busy", {31'd0, Busy_out}, 32'd1);
    drive(1'b1, F_MFLO, '0, '0);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Stall_out) cycles++;
      else break;
    end
    check("mflo_stall_cycles", cycles, 32'd33);
    check("mflo_after_stall", O_out, 32'd42);
    drive(1'b1, F_MFHI, '0, '0);
    check("mfhi_after_stall", O_out, 32'd0);
    drive(1'b0, F_ADD, '0, '0);

    // Reset in the middle of a DIV
    drive(1'b1, F_DIV, 32'd100, 32'd7);
    tick();
    drive(1'b1, F_MFLO, '0, '0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, Busy_out}, 32'd0);
    check("midrst_mflo", O_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, F_MFHI, '0, '0);
    check("postrst_mfhi", O_out, 32'd0);
    drive(1'b1, F_MFLO, '0, '0);
    check("postrst_mflo", O_out, 32'd0);
    tick();
    tick();
    check("postrst_busy", {31'd0, Busy_out}, 32'd0);

    // MTHI / MTLO
    drive(1'b1, F_MTHI, 32'hCAFEF00D, 32'h11111111);
    check("mthi_o", O_out, 32'h11111111);
    tick();
    drive(1'b1, F_MTLO, 32'h12345678, 32'h0);
    tick();
    drive(1'b1, F_MFHI, '0, '0);
    check("mthi_read", O_out, 32'hCAFEF00D);
    drive(1'b1, F_MFLO, '0, '0);
    check("mtlo_read", O_out, 32'h12345678);

    // Combinational ops
    drive(1'b1, F_SUB, 32'd5, 32'd7);
    check("sub", O_out, 32'hFFFFFFFE);
    check("sub_branch", {31'd0, Branch_out}, 32'd0);
    drive(1'b1, F_NOR, 32'h0000FFFF, 32'h00FF0000);
    check("nor", O_out, 32'hFF000000);
    drive(1'b1, F_SLT, 32'hFFFFFFFF, 32'd1);
    check("slt", O_out, 32'd1);
    drive(1'b1, F_SLTU, 32'hFFFFFFFF, 32'd1);
    check("sltu", O_out, 32'd0);
    drive(1'b1, F_BEQ, 32'h55AA55AA, 32'h55AA55AA);
    check("beq_taken", {31'd0, Branch_out}, 32'd1);
    check("beq_o", O_out, 32'h55AA55AA);
    check("beq_jump", {31'd0, Jump_out}, 32'd0);
    drive(1'b1, F_BNE, 32'h55AA55AA, 32'h55AA55AA);
    check("bne_not_taken", {31'd0, Branch_out}, 32'd0);
    drive(1'b1, F_BLTZ, 32'hFFFFFFFF, 32'd0);
    check("bltz_taken", {31'd0, Branch_out}, 32'd1);
    drive(1'b1, F_J, 32'd0, 32'd0);
    check("jump", {31'd0, Jump_out}, 32'd1);
    drive(1'b1, 6'b000000, 32'd9, 32'hABCD0123);
    check("other_op", O_out, 32'hABCD0123);

    drive(1'b0, F_ADD, '0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
